commitment_verify: RTL and testbench
====================================

Name: commitment_verify

Overview:
- Verifier-side counterpart of the commitment generator.
- Takes the revealed per-party seeds and the received commitment vector C.
- Recomputes each opened party's commitment through an external commitment hash unit (H_for_C1-style request/response handshake) and compares it against the received value.
- Reports pass/fail and the first mismatching party index. Used in the Picnic-on-SM4 verify path, one instance per checked round (t, j).

Parameters:
- NPARTY, 15, number of parties (seeds/commitments per round)
- SEED_W, 128, width of one party seed
- HASH_W, 256, width of one commitment

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- ver_start  input  1  start request, sampled only in IDLE
- seed  input  SEED_W*NPARTY  revealed seeds; party 0 in the top SEED_W bits, party k at [SEED_W*(NPARTY-k)-1 -: SEED_W]
- c_in  input  HASH_W*NPARTY  received commitments, same MSB-first packing
- unopened  input  8  index of the hidden party; a value >= NPARTY means all parties are checked
- ver_end  output  1  one-cycle done pulse
- ver_pass  output  1  1 = all checked commitments matched; valid from ver_end, held until the next accepted start
- fail_idx  output  8  first mismatching party; 8'hFF on pass
- hash_start  output  1  hash request, held high until hash_end
- hash_seed  output  SEED_W  seed presented to the hash unit
- hash_idx  output  8  party index presented to the hash unit (the hash's i input)
- hash_end  input  1  one-cycle hash completion pulse
- hash_value  input  HASH_W  hash result, valid in the cycle hash_end=1

Behaviour:
- Reset (synchronous, active-high): all outputs 0 except fail_idx=8'hFF; state=IDLE; index counter=0. Aborts any run in progress. hash_start drops in the cycle after reset is sampled.
- FSM states: IDLE, SKIP, REQ, WAIT, CMP, DONE.
- IDLE:
  - On ver_start=1, latch seed, c_in and unopened into internal registers; later input changes have no effect.
  - Clear ver_pass, set fail_idx=8'hFF, set i=0, go to SKIP.
- SKIP (1 cycle):
  - If i==NPARTY, go to DONE.
  - Else if i==unopened_latched, increment i and stay in SKIP.
  - Else drive hash_seed=seed[i] and hash_idx=i, and go to REQ.
- REQ: assert hash_start, go to WAIT.
- WAIT:
  - Hold hash_start, hash_seed and hash_idx stable.
  - On hash_end=1, capture hash_value into a compare register, deassert hash_start next cycle, go to CMP.
- CMP:
  - If captured value != c_in[i]: fail_idx=i, ver_pass=0, go to DONE. Abort on first mismatch; remaining parties are not hashed.
  - Else increment i and go to SKIP.
- DONE: ver_end=1 for exactly one cycle. ver_pass=1 if no mismatch occurred. Return to IDLE.
- Latency with a fixed hash latency L (hash_end L cycles after the first cycle hash_start=1): each checked party costs L+3 cycles, each skipped party 1 cycle, plus 2 cycles of start/done overhead.
- ver_start while not in IDLE is ignored; a level-held ver_start restarts one cycle after DONE.
- hash_end outside WAIT is ignored.
- Comparison is exact over all HASH_W bits.
- When unopened >= NPARTY, all NPARTY parties are hashed.

Test Plan:
- Bench hash model: L=3, returns {hash_seed, hash_seed ^ hash_idx}. Use seed[k]=128'h1000+k, c_in built from the model, unopened=8'hFF, pulse ver_start -> 15 hash requests with hash_idx 0..14 in order, ver_end once, ver_pass=1, fail_idx=8'hFF.
- Same setup with unopened=5 and c_in[5] filled with garbage -> hash_idx never equals 5, ver_pass=1, exactly 14 requests.
- Corrupt bit 0 of c_in[7], unopened=8'hFF -> ver_pass=0, fail_idx=7, exactly 8 hash requests issued, ver_end asserted 2 cycles after the 8th hash_end.
- Corrupt c_in[0] and c_in[14] -> fail_idx=0 after a single request.
- Assert reset during the 4th WAIT -> next cycle: hash_start=0, ver_end=0, fail_idx=8'hFF. A fresh ver_start then runs a full pass correctly.
- Pulse ver_start again mid-run and change seed after start -> neither affects the run; results match the latched values.

Source files
------------

// File: rtl/commitment_verify.sv
// commitment_verify
//   Verifier-side commitment check for one round. The revealed party seeds are
//   re-hashed one at a time through an external commitment hash unit. Each
//   result is compared against the received commitment for that party. The
//   hidden (unopened) party is skipped, and the run stops at the first mismatch.
//
// Ports
//   clk, reset   system clock; synchronous active-high reset
//   ver_start    start request, only honoured while idle
//   seed         NPARTY revealed seeds, party 0 in the most significant slot
//   c_in         NPARTY received commitments, same MSB-first packing
//   unopened     hidden party index; >= NPARTY means every party is checked
//   ver_end      one-cycle completion pulse
//   ver_pass     1 when every checked commitment matched (held until next start)
//   fail_idx     first mismatching party, 8'hFF when none
//   hash_start   request to the hash unit, held until hash_end
//   hash_seed    seed presented to the hash unit
//   hash_idx     party index presented to the hash unit
//   hash_end     one-cycle hash completion pulse
//   hash_value   hash result, valid while hash_end is high
module commitment_verify #(
  parameter int NPARTY = 15,
  parameter int SEED_W = 128,
  parameter int HASH_W = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ver_start,
  input  logic [SEED_W*NPARTY-1:0] seed,
  input  logic [HASH_W*NPARTY-1:0] c_in,
  input  logic [7:0]               unopened,
  output logic                     ver_end,
  output logic                     ver_pass,
  output logic [7:0]               fail_idx,
  output logic                     hash_start,
  output logic [SEED_W-1:0]        hash_seed,
  output logic [7:0]               hash_idx,
  input  logic                     hash_end,
  input  logic [HASH_W-1:0]        hash_value
);

  localparam int AW = (NPARTY > 1) ? $clog2(NPARTY) : 1;
  localparam logic [7:0] NP8 = 8'(NPARTY);

  typedef enum logic [2:0] {IDLE, SKIP, REQ, WAIT, CMP, DONE} state_t;

  state_t            state;
  logic [7:0]        i;
  logic [7:0]        unop_l;
  logic [HASH_W-1:0] cmp_val;
  logic [SEED_W-1:0] seed_arr [NPARTY];
  logic [HASH_W-1:0] c_arr    [NPARTY];

  // hash_start is raised on the SKIP->REQ transition so it is already high in
  // REQ; that makes a checked party cost SKIP + REQ + L WAIT cycles + CMP.
  // ver_end and ver_pass are set on the transition into DONE, so the pulse
  // lines up with the DONE cycle itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      i          <= 8'd0;
      unop_l     <= 8'd0;
      cmp_val    <= '0;
      ver_end    <= 1'b0;
      ver_pass   <= 1'b0;
      fail_idx   <= 8'hFF;
      hash_start <= 1'b0;
      hash_seed  <= '0;
      hash_idx   <= 8'd0;
    end else begin
      ver_end <= 1'b0;
      case (state)
        IDLE: begin
          if (ver_start) begin
            for (int k = 0; k < NPARTY; k++) begin
              seed_arr[k] <= seed[SEED_W*(NPARTY-k)-1 -: SEED_W];
              c_arr[k]    <= c_in[HASH_W*(NPARTY-k)-1 -: HASH_W];
            end
            unop_l   <= unopened;
            ver_pass <= 1'b0;
            fail_idx <= 8'hFF;
            i        <= 8'd0;
            state    <= SKIP;
          end
        end
        SKIP: begin
          if (i == NP8) begin
            ver_pass <= 1'b1;
            ver_end  <= 1'b1;
            state    <= DONE;
          end else if (i == unop_l) begin
            i <= i + 8'd1;
          end else begin
            hash_seed  <= seed_arr[i[AW-1:0]];
            hash_idx   <= i;
            hash_start <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          state <= WAIT;
        end
        WAIT: begin
          if (hash_end) begin
            cmp_val    <= hash_value;
            hash_start <= 1'b0;
            state      <= CMP;
          end
        end
        CMP: begin
          // First mismatch ends the run; later parties are never hashed.
          if (cmp_val != c_arr[i[AW-1:0]]) begin
            fail_idx <= i;
            ver_pass <= 1'b0;
            ver_end  <= 1'b1;
            state    <= DONE;
          end else begin
            i     <= i + 8'd1;
            state <= SKIP;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_commitment_verify.sv
`timescale 1ns/1ps
// tb_commitment_verify
//   Randomised and directed bench for commitment_verify. A hash unit model
//   answers each request three cycles after hash_start rises. A behavioural
//   reference predicts the requested party sequence, the verdict and the
//   completion cycle for every run.
module tb_commitment_verify;

  localparam int NP = 15;
  localparam int SW = 128;
  localparam int HW = 256;
  localparam int L  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              ver_start;
  logic [SW*NP-1:0]  seed;
  logic [HW*NP-1:0]  c_in;
  logic [7:0]        unopened;
  logic              ver_end;
  logic              ver_pass;
  logic [7:0]        fail_idx;
  logic              hash_start;
  logic [SW-1:0]     hash_seed;
  logic [7:0]        hash_idx;
  logic              hash_end;
  logic [HW-1:0]     hash_value;

  commitment_verify #(.NPARTY(NP), .SEED_W(SW), .HASH_W(HW)) dut (
    .clk(clk), .reset(reset), .ver_start(ver_start), .seed(seed), .c_in(c_in),
    .unopened(unopened), .ver_end(ver_end), .ver_pass(ver_pass),
    .fail_idx(fail_idx), .hash_start(hash_start), .hash_seed(hash_seed),
    .hash_idx(hash_idx), .hash_end(hash_end), .hash_value(hash_value)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // stimulus tables and the reference snapshot taken at start
  logic [SW-1:0] s_tab [NP];
  logic [HW-1:0] c_tab [NP];
  logic [7:0]    u_val;
  logic [SW-1:0] m_seed [NP];
  int            exp_idx [$];
  int            exp_n;
  bit            exp_pass;
  logic [7:0]    exp_fidx;
  int            exp_done;
  int            t0;

  // run observations
  int   req_cnt;
  int   end_cnt;
  int   done_cyc;
  int   last_he;
  bit   mon_en  = 1'b0;
  bit   spur_en = 1'b0;
  logic prev_hs = 1'b0;

  // hash model state
  bit active = 1'b0;
  int hcnt   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [HW-1:0] hash_fn(input logic [SW-1:0] s, input logic [7:0] idx);
    return {s, s ^ {{(SW-8){1'b0}}, idx}};
  endfunction

  task automatic chk(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Hash unit: answers L cycles after the first cycle hash_start is seen,
  // optionally throwing in stray hash_end pulses while no request is open.
  always @(negedge clk) begin
    hash_end = 1'b0;
    if (!hash_start) begin
      active = 1'b0;
      if (spur_en && $urandom_range(0, 3) == 0) begin
        hash_end   = 1'b1;
        hash_value = {8{$urandom}};
      end
    end else if (!active) begin
      active = 1'b1;
      hcnt   = 0;
    end else begin
      hcnt++;
      if (hcnt == L) begin
        hash_end   = 1'b1;
        hash_value = hash_fn(hash_seed, hash_idx);
        last_he    = cyc;
      end
    end
  end

  // Compare process: every request must follow the predicted party order
  // with the latched seed, and ver_end must come on the predicted cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (hash_start && !prev_hs) req_cnt++;
      if (hash_start) begin
        if (req_cnt > exp_n) begin
          chk("extra_request", req_cnt, exp_n);
        end else begin
          chk("hash_idx", hash_idx, exp_idx[req_cnt-1]);
          chk("hash_seed", hash_seed, m_seed[exp_idx[req_cnt-1]]);
        end
      end
      if (ver_end) begin
        end_cnt++;
        done_cyc = cyc;
        chk("ver_end_cycle", cyc, exp_done);
        chk("ver_pass_at_end", ver_pass, exp_pass);
        chk("fail_idx_at_end", fail_idx, exp_fidx);
      end
    end
    prev_hs = hash_start;
  end

  task automatic pack_inputs();
    for (int k = 0; k < NP; k++) begin
      seed[SW*(NP-k)-1 -: SW] = s_tab[k];
      c_in[HW*(NP-k)-1 -: HW] = c_tab[k];
    end
    unopened = u_val;
  endtask

  // Reference: walk parties in order, skip the hidden one, stop on mismatch.
  // Each checked party costs L+3 cycles, a skip 1, the final empty SKIP 1.
  task automatic build_model();
    int skipped;
    skipped = 0;
    exp_idx.delete();
    exp_pass = 1'b1;
    exp_fidx = 8'hFF;
    for (int k = 0; k < NP; k++) m_seed[k] = s_tab[k];
    for (int k = 0; k < NP; k++) begin
      if (k == int'(u_val)) begin
        skipped++;
        continue;
      end
      exp_idx.push_back(k);
      if (hash_fn(s_tab[k], 8'(k)) != c_tab[k]) begin
        exp_pass = 1'b0;
        exp_fidx = 8'(k);
        break;
      end
    end
    exp_n    = exp_idx.size();
    exp_done = t0 + 1 + (L + 3) * exp_n + skipped + (exp_pass ? 1 : 0);
  endtask

  task automatic setup_directed();
    for (int k = 0; k < NP; k++) begin
      s_tab[k] = 128'h1000 + k;
      c_tab[k] = hash_fn(s_tab[k], 8'(k));
    end
    u_val = 8'hFF;
  endtask

  task automatic applyStimulus(input bit perturb);
    @(negedge clk);
    pack_inputs();
    ver_start = 1'b1;
    t0        = cyc;
    build_model();
    req_cnt   = 0;
    end_cnt   = 0;
    done_cyc  = -1;
    last_he   = -1;
    mon_en    = 1'b1;
    @(negedge clk);
    ver_start = 1'b0;
    if (perturb) begin
      repeat (2) @(negedge clk);
      ver_start = 1'b1;
      seed      = {60{$urandom}};
      c_in      = {120{$urandom}};
      unopened  = 8'($urandom);
      @(negedge clk);
      ver_start = 1'b0;
    end
  endtask

  task automatic checkOutput(input bit use_lit, input int lit_n, input bit lit_pass,
                             input logic [7:0] lit_fidx);
    for (int w = 0; w < 400 && end_cnt == 0; w++) begin
      @(negedge clk);
      #1;
    end
    chk("ver_end_seen", end_cnt != 0, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("ver_end_count", end_cnt, 1);
    chk("request_count", req_cnt, exp_n);
    chk("ver_pass_held", ver_pass, exp_pass);
    chk("fail_idx_held", fail_idx, exp_fidx);
    if (use_lit) begin
      chk("model_request_count", exp_n, lit_n);
      chk("model_pass", exp_pass, lit_pass);
      chk("model_fail_idx", exp_fidx, lit_fidx);
      chk("lit_request_count", req_cnt, lit_n);
      chk("lit_ver_pass", ver_pass, lit_pass);
      chk("lit_fail_idx", fail_idx, lit_fidx);
    end
    if (!exp_pass && last_he >= 0) chk("hash_end_to_ver_end", done_cyc - last_he, 2);
    mon_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    ver_start = 1'b0;
    seed      = '0;
    c_in      = '0;
    unopened  = 8'd0;
    hash_end  = 1'b0;
    hash_value = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_hash_start", hash_start, 1'b0);
    chk("rst_ver_end", ver_end, 1'b0);
    chk("rst_ver_pass", ver_pass, 1'b0);
    chk("rst_fail_idx", fail_idx, 8'hFF);
    chk("rst_hash_idx", hash_idx, 8'd0);
    chk("rst_hash_seed", hash_seed, '0);
    reset = 1'b0;

    $display("[TB] all parties open, all match");
    setup_directed();
    applyStimulus(1'b0);
    checkOutput(1'b1, 15, 1'b1, 8'hFF);

    $display("[TB] party 5 hidden with garbage commitment");
    setup_directed();
    u_val    = 8'd5;
    c_tab[5] = {8{32'hDEADBEEF}};
    applyStimulus(1'b0);
    checkOutput(1'b1, 14, 1'b1, 8'hFF);

    $display("[TB] bit 0 of party 7 commitment flipped");
    setup_directed();
    c_tab[7][0] = ~c_tab[7][0];
    applyStimulus(1'b0);
    checkOutput(1'b1, 8, 1'b0, 8'd7);

    $display("[TB] parties 0 and 14 corrupted");
    setup_directed();
    c_tab[0]  = ~c_tab[0];
    c_tab[14] = c_tab[14] ^ 256'h1;
    applyStimulus(1'b0);
    checkOutput(1'b1, 1, 1'b0, 8'd0);

    $display("[TB] reset during fourth hash wait");
    setup_directed();
    applyStimulus(1'b0);
    for (int w = 0; w < 200 && req_cnt < 4; w++) begin
      @(negedge clk);
      #1;
    end
    chk("reached_fourth_request", req_cnt, 4);
    @(negedge clk);
    mon_en = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_hash_start", hash_start, 1'b0);
    chk("abort_ver_end", ver_end, 1'b0);
    chk("abort_fail_idx", fail_idx, 8'hFF);
    chk("abort_ver_pass", ver_pass, 1'b0);
    reset = 1'b0;
    setup_directed();
    applyStimulus(1'b0);
    checkOutput(1'b1, 15, 1'b1, 8'hFF);

    $display("[TB] restart pulse and input changes mid-run");
    setup_directed();
    applyStimulus(1'b1);
    checkOutput(1'b1, 15, 1'b1, 8'hFF);
    setup_directed();
    u_val       = 8'd2;
    c_tab[9][200] = ~c_tab[9][200];
    applyStimulus(1'b1);
    checkOutput(1'b1, 9, 1'b0, 8'd9);

    $display("[TB] randomised runs");
    spur_en = 1'b1;
    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < NP; k++) begin
        s_tab[k] = {$urandom, $urandom, $urandom, $urandom};
        c_tab[k] = hash_fn(s_tab[k], 8'(k));
      end
      if ($urandom_range(0, 2) == 0) u_val = 8'($urandom_range(15, 255));
      else                           u_val = 8'($urandom_range(0, 14));
      if ($urandom_range(0, 1) == 1) begin
        int p;
        int b;
        p = $urandom_range(0, NP - 1);
        b = $urandom_range(0, HW - 1);
        c_tab[p][b] = ~c_tab[p][b];
      end
      applyStimulus(bit'($urandom_range(0, 1)));
      checkOutput(1'b0, 0, 1'b0, 8'h00);
    end
    spur_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
